// File: rtl/uart_telemetry_link_if.sv
// Byte-level link between the telemetry framer and the duplex UART core.
// master = framer/parser side, slave = UART core side.
`timescale 1ns/1ps
interface uart_telemetry_link_if;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] rx_byte;
    logic       rx_valid;

    modport master (
        output tx_byte, tx_start,
        input  tx_busy, tx_done, rx_byte, rx_valid
    );

    modport slave (
        input  tx_byte, tx_start,
        output tx_busy, tx_done, rx_byte, rx_valid
    );
endinterface

// File: rtl/uart_telemetry_link.sv
// UART telemetry framer and command parser.
// TX: every PERIOD cycles snapshot NUM_CH channels, convert each to DIGITS
// ASCII decimal digits (saturating at all '9') and send "S:<digits>\n".
// RX: parse "L:<b0>..<bN-1>\n" frames and apply the bits to o_out_ctrl.
`timescale 1ns/1ps
module uart_telemetry_link #(
    parameter int NUM_CH  = 2,
    parameter int CH_W    = 16,
    parameter int DIGITS  = 3,
    parameter int PERIOD  = 1000000,
    parameter int NUM_OUT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic [NUM_CH*CH_W-1:0] i_ch_data,
    uart_telemetry_link_if.master  bus,
    output logic [NUM_OUT-1:0]     o_out_ctrl,
    output logic                   o_frame_sent,
    output logic                   o_tick_overrun,
    output logic                   o_cmd_ok,
    output logic                   o_cmd_err
);
    localparam int NDIG      = NUM_CH * DIGITS;
    localparam int FRAME_LEN = 3 + NDIG;
    localparam int BW        = $clog2(FRAME_LEN);
    localparam int PW        = $clog2(PERIOD);
    localparam int CW        = (NUM_CH > 1)  ? $clog2(NUM_CH)  : 1;
    localparam int KW        = (DIGITS > 1)  ? $clog2(DIGITS)  : 1;
    localparam int DW        = (NDIG > 1)    ? $clog2(NDIG)    : 1;
    localparam int OW        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [31:0] LIMIT = 32'(10**DIGITS);

    localparam logic [7:0] C_S     = 8'h53;
    localparam logic [7:0] C_L     = 8'h4C;
    localparam logic [7:0] C_COLON = 8'h3A;
    localparam logic [7:0] C_NL    = 8'h0A;

    typedef enum logic [1:0] {T_IDLE, T_CONV, T_SEND} tx_state_t;
    typedef enum logic [1:0] {R_CMD, R_COLON, R_BIT, R_NL} rx_state_t;

    // ---------------- channel slicing and digit weights ----------------
    logic [CH_W-1:0] w_ch  [NUM_CH];
    logic [31:0]     w_pow [DIGITS];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_ch[gi] = i_ch_data[gi*CH_W +: CH_W];
    end

    // Digit 0 is the most significant one, so it carries the largest weight.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pow
        assign w_pow[gi] = 32'(10**(DIGITS-1-gi));
    end

    // ---------------- period counter ----------------
    logic [PW-1:0] r_per;
    logic          w_tick;

    assign w_tick = i_enable && (r_per == PW'(PERIOD-1));

    // Free-running period counter, parked at 0 while TX is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_per <= '0;
        else if (!i_enable)  r_per <= '0;
        else if (w_tick)     r_per <= '0;
        else                 r_per <= r_per + 1'b1;
    end

    // ---------------- TX framer ----------------
    tx_state_t       r_tx_state;
    logic [CH_W-1:0] r_snap   [NUM_CH];
    logic [3:0]      r_digits [NDIG];
    logic [31:0]     r_rem;
    logic [3:0]      r_cnt;
    logic [CW-1:0]   r_ch;
    logic [KW-1:0]   r_dig;
    logic [DW-1:0]   r_didx;
    logic [BW-1:0]   r_bidx;
    logic            r_wait;
    logic [7:0]      r_tx_byte;
    logic            r_tx_start;
    logic            r_frame_sent;
    logic            r_tick_overrun;

    logic [CW-1:0]   w_ch_next;
    logic            w_sat;
    logic [DW-1:0]   w_dsel;
    logic [7:0]      w_byte;

    assign w_ch_next = r_ch + 1'b1;
    assign w_sat     = 32'(r_snap[r_ch]) >= LIMIT;
    assign w_dsel    = DW'(r_bidx - BW'(2));

    // Frame byte selected by the send index: header, digits, terminator.
    always_comb begin
        w_byte = C_NL;
        if (r_bidx == BW'(0))                  w_byte = C_S;
        else if (r_bidx == BW'(1))             w_byte = C_COLON;
        else if (r_bidx < BW'(FRAME_LEN-1))    w_byte = 8'h30 + {4'h0, r_digits[w_dsel]};
    end

    // TX FSM: snapshot on tick, repeated-subtraction conversion, byte handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state     <= T_IDLE;
            r_rem          <= '0;
            r_cnt          <= '0;
            r_ch           <= '0;
            r_dig          <= '0;
            r_didx         <= '0;
            r_bidx         <= '0;
            r_wait         <= 1'b0;
            r_tx_byte      <= 8'h00;
            r_tx_start     <= 1'b0;
            r_frame_sent   <= 1'b0;
            r_tick_overrun <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_snap[i]   <= '0;
            for (int i = 0; i < NDIG; i++)   r_digits[i] <= '0;
        end else begin
            r_tx_start     <= 1'b0;
            r_frame_sent   <= 1'b0;
            // A tick that lands mid-frame is only reported, never acted on.
            r_tick_overrun <= w_tick && (r_tx_state != T_IDLE);
            case (r_tx_state)
                T_IDLE: begin
                    if (w_tick) begin
                        for (int i = 0; i < NUM_CH; i++) r_snap[i] <= w_ch[i];
                        r_rem      <= 32'(w_ch[0]);
                        r_cnt      <= '0;
                        r_ch       <= '0;
                        r_dig      <= '0;
                        r_didx     <= '0;
                        r_tx_state <= T_CONV;
                    end
                end
                T_CONV: begin
                    // Store the digit once the remainder drops below the weight
                    // (at most 9 subtractions + 1 store cycle per digit).
                    if (w_sat || (r_rem < w_pow[r_dig]) || (r_cnt == 4'd9)) begin
                        r_digits[r_didx] <= w_sat ? 4'd9 : r_cnt;
                        r_didx           <= r_didx + 1'b1;
                        r_cnt            <= '0;
                        if (r_dig == KW'(DIGITS-1)) begin
                            r_dig <= '0;
                            if (r_ch == CW'(NUM_CH-1)) begin
                                r_bidx     <= '0;
                                r_wait     <= 1'b0;
                                r_tx_state <= T_SEND;
                            end else begin
                                r_ch  <= w_ch_next;
                                r_rem <= 32'(r_snap[w_ch_next]);
                            end
                        end else begin
                            r_dig <= r_dig + 1'b1;
                        end
                    end else begin
                        r_rem <= r_rem - w_pow[r_dig];
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                T_SEND: begin
                    if (r_wait) begin
                        if (bus.tx_done) begin
                            r_wait <= 1'b0;
                            if (r_bidx == BW'(FRAME_LEN-1)) begin
                                r_frame_sent <= 1'b1;
                                r_tx_state   <= T_IDLE;
                            end else begin
                                r_bidx <= r_bidx + 1'b1;
                            end
                        end
                    end else if (!bus.tx_busy) begin
                        r_tx_byte  <= w_byte;
                        r_tx_start <= 1'b1;
                        r_wait     <= 1'b1;
                    end
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    assign bus.tx_byte     = r_tx_byte;
    assign bus.tx_start    = r_tx_start;
    assign o_frame_sent    = r_frame_sent;
    assign o_tick_overrun  = r_tick_overrun;

    // ---------------- RX command parser ----------------
    rx_state_t        r_rx_state;
    logic [OW-1:0]    r_ridx;
    logic [NUM_OUT-1:0] r_shadow;
    logic [NUM_OUT-1:0] r_out_ctrl;
    logic             r_cmd_ok;
    logic             r_cmd_err;
    rx_state_t        w_resync;

    // An unexpected 'L' is treated as the start of a fresh command.
    assign w_resync = (bus.rx_byte == C_L) ? R_COLON : R_CMD;

    // RX FSM: only rx_valid cycles advance; outputs change only on a complete frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= R_CMD;
            r_ridx     <= '0;
            r_shadow   <= '0;
            r_out_ctrl <= '0;
            r_cmd_ok   <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_ok  <= 1'b0;
            r_cmd_err <= 1'b0;
            if (bus.rx_valid) begin
                case (r_rx_state)
                    R_CMD: begin
                        if (bus.rx_byte == C_L) r_rx_state <= R_COLON;
                    end
                    R_COLON: begin
                        if (bus.rx_byte == C_COLON) begin
                            r_ridx     <= '0;
                            r_rx_state <= R_BIT;
                        end else begin
                            r_cmd_err  <= 1'b1;
                            r_rx_state <= w_resync;
                        end
                    end
                    R_BIT: begin
                        if (bus.rx_byte == 8'h30 || bus.rx_byte == 8'h31) begin
                            r_shadow[r_ridx] <= bus.rx_byte[0];
                            if (r_ridx == OW'(NUM_OUT-1)) r_rx_state <= R_NL;
                            else                          r_ridx     <= r_ridx + 1'b1;
                        end else begin
                            r_cmd_err  <= 1'b1;
                            r_rx_state <= w_resync;
                        end
                    end
                    R_NL: begin
                        if (bus.rx_byte == C_NL) begin
                            r_out_ctrl <= r_shadow;
                            r_cmd_ok   <= 1'b1;
                            r_rx_state <= R_CMD;
                        end else begin
                            r_cmd_err  <= 1'b1;
                            r_rx_state <= w_resync;
                        end
                    end
                    default: r_rx_state <= R_CMD;
                endcase
            end
        end
    end

    assign o_out_ctrl = r_out_ctrl;
    assign o_cmd_ok   = r_cmd_ok;
    assign o_cmd_err  = r_cmd_err;
endmodule

// File: tb/tb_uart_telemetry_link.sv
// Directed bench for uart_telemetry_link: expected TX bytes are queued when a
// frame is stimulated and popped by the UART model as bytes are issued.
`timescale 1ns/1ps
module tb_uart_telemetry_link;
    localparam int NUM_CH  = 2;
    localparam int CH_W    = 16;
    localparam int DIGITS  = 3;
    localparam int PERIOD  = 20;
    localparam int NUM_OUT = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   enable = 1'b0;
    logic [NUM_CH*CH_W-1:0] ch_data = '0;
    logic [NUM_OUT-1:0]     out_ctrl;
    logic                   frame_sent, tick_overrun, cmd_ok, cmd_err;

    uart_telemetry_link_if bus();

    uart_telemetry_link #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DIGITS(DIGITS), .PERIOD(PERIOD), .NUM_OUT(NUM_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_ch_data(ch_data), .bus(bus),
        .o_out_ctrl(out_ctrl), .o_frame_sent(frame_sent), .o_tick_overrun(tick_overrun),
        .o_cmd_ok(cmd_ok), .o_cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_bytes = 0;
    int         start_cyc = 0;
    int         n_frames = 0;
    int         n_overrun = 0;
    int         uart_delay = 1;
    logic [7:0] exp_q[$];
    logic [7:0] cur_byte;
    logic [7:0] exp_byte;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse counters for frame_sent and tick_overrun.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_sent === 1'b1)   n_frames++;
            if (tick_overrun === 1'b1) n_overrun++;
        end
    end

    // UART TX core model: accepts a byte on tx_start, busy for uart_delay cycles, then tx_done.
    initial begin
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (bus.tx_start === 1'b1) begin
                cur_byte  = bus.tx_byte;
                n_bytes++;
                start_cyc = cyc;
                $display("tx byte %02h at cycle %0d", cur_byte, cyc);
                if (exp_q.size() == 0) begin
                    check("tx_extra_byte", 32'(cur_byte), 32'hFFFF_FFFF);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("tx_byte", 32'(cur_byte), 32'(exp_byte));
                end
                bus.tx_busy = 1'b1;
                for (int i = 1; i < uart_delay; i++) begin
                    @(negedge clk);
                    check("tx_start_while_busy", 32'(bus.tx_start), 32'd0);
                    check("tx_byte_hold", 32'(bus.tx_byte), 32'(cur_byte));
                end
                @(negedge clk);
                check("tx_start_before_done", 32'(bus.tx_start), 32'd0);
                bus.tx_done = 1'b1;
                bus.tx_busy = 1'b0;
            end
        end
    end

    task automatic push_frame(input int a, input int b);
        int v[2];
        int s;
        v[0] = a;
        v[1] = b;
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h3A);
        for (int c = 0; c < 2; c++) begin
            s = (v[c] > 999) ? 999 : v[c];
            exp_q.push_back(8'(48 + s / 100));
            exp_q.push_back(8'(48 + (s / 10) % 10));
            exp_q.push_back(8'(48 + s % 10));
        end
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (frame_sent === 1'b1) seen = 1'b1;
        end
        check({tag, "_frame_sent"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int target);
        for (int i = 0; i < 1500 && n_bytes < target; i++) @(negedge clk);
        check({tag, "_byte_seen"}, 32'(n_bytes >= target), 32'd1);
    endtask

    // One complete frame with enable dropped as soon as frame_sent is seen.
    task automatic run_frame(input string tag, input int a, input int b);
        int f0;
        ch_data = {16'(b), 16'(a)};
        push_frame(a, b);
        f0 = n_frames;
        enable = 1'b1;
        wait_frame(tag);
        enable = 1'b0;
        check({tag, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
        repeat (30) @(negedge clk);
        check({tag, "_one_frame"}, 32'(n_frames - f0), 32'd1);
    endtask

    task automatic rx(input logic [7:0] b, input logic e_ok, input logic e_err, input logic [1:0] e_out);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        $display("rx byte %02h: cmd_ok=%0b cmd_err=%0b out_ctrl=%b", b, cmd_ok, cmd_err, out_ctrl);
        check("rx_cmd_ok", 32'(cmd_ok), 32'(e_ok));
        check("rx_cmd_err", 32'(cmd_err), 32'(e_err));
        check("rx_out_ctrl", 32'(out_ctrl), 32'(e_out));
        @(negedge clk);
        check("rx_ok_pulse", 32'(cmd_ok), 32'd0);
        check("rx_err_pulse", 32'(cmd_err), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check({tag, "_tx_byte"}, 32'(bus.tx_byte), 32'd0);
        check({tag, "_out_ctrl"}, 32'(out_ctrl), 32'd0);
        check({tag, "_frame_sent"}, 32'(frame_sent), 32'd0);
        check({tag, "_overrun"}, 32'(tick_overrun), 32'd0);
        check({tag, "_cmd_ok"}, 32'(cmd_ok), 32'd0);
        check({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
    endtask

    initial begin
        int b0;
        int ov0;
        int c0;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, saturation and zero
        run_frame("basic", 75, 98);
        run_frame("sat", 1234, 0);

        // Snapshot: inputs change after the first byte is on the wire
        ch_data = {16'd321, 16'd5};
        push_frame(5, 321);
        b0 = n_bytes;
        enable = 1'b1;
        wait_bytes("snap", b0 + 1);
        ch_data = {16'd0, 16'd60};
        wait_frame("snap");
        enable = 1'b0;
        check("snap_all_bytes", 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk);

        // Slow UART: frame is far longer than PERIOD, ticks must be flagged only
        uart_delay = 6;
        ov0 = n_overrun;
        run_frame("slow", 7, 42);
        check("slow_overrun_seen", 32'(n_overrun > ov0), 32'd1);
        uart_delay = 1;
        ov0 = n_overrun;
        repeat (50) @(negedge clk);
        check("idle_no_overrun", 32'(n_overrun), 32'(ov0));

        // RX command parsing
        rx(8'h4C, 0, 0, 2'b00); rx(8'h3A, 0, 0, 2'b00); rx(8'h31, 0, 0, 2'b00);
        rx(8'h30, 0, 0, 2'b00); rx(8'h0A, 1, 0, 2'b01);
        rx(8'h4C, 0, 0, 2'b01); rx(8'h3A, 0, 0, 2'b01); rx(8'h31, 0, 0, 2'b01);
        rx(8'h78, 0, 1, 2'b01); rx(8'h0A, 0, 0, 2'b01);
        rx(8'h51, 0, 0, 2'b01);
        rx(8'h4C, 0, 0, 2'b01); rx(8'h58, 0, 1, 2'b01);
        rx(8'h4C, 0, 0, 2'b01); rx(8'h3A, 0, 0, 2'b01); rx(8'h30, 0, 0, 2'b01);
        rx(8'h31, 0, 0, 2'b01); rx(8'h31, 0, 1, 2'b01);
        rx(8'h4C, 0, 0, 2'b01); rx(8'h3A, 0, 0, 2'b01); rx(8'h4C, 0, 1, 2'b01);
        rx(8'h3A, 0, 0, 2'b01); rx(8'h30, 0, 0, 2'b01); rx(8'h31, 0, 0, 2'b01);
        rx(8'h0A, 1, 0, 2'b10);
        // rx_byte without rx_valid must not advance the parser
        bus.rx_byte = 8'h4C;
        repeat (3) @(negedge clk);
        rx(8'h3A, 0, 0, 2'b10); rx(8'h30, 0, 0, 2'b10); rx(8'h31, 0, 0, 2'b10);
        rx(8'h0A, 0, 0, 2'b10);

        // Reset in the middle of both an RX frame and a TX frame
        rx(8'h4C, 0, 0, 2'b10); rx(8'h3A, 0, 0, 2'b10); rx(8'h31, 0, 0, 2'b10);
        ch_data = {16'd22, 16'd11};
        push_frame(11, 22);
        b0 = n_bytes;
        enable = 1'b1;
        wait_bytes("midrst", b0 + 3);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (8) @(negedge clk);
        push_frame(11, 22);
        b0 = n_bytes;
        c0 = cyc;
        rst_n = 1'b1;
        wait_bytes("postrst", b0 + 1);
        check("postrst_full_period", 32'((start_cyc - c0) >= PERIOD), 32'd1);
        wait_frame("postrst");
        enable = 1'b0;
        check("postrst_all_bytes", 32'(exp_q.size()), 32'd0);
        rx(8'h30, 0, 0, 2'b00); rx(8'h0A, 0, 0, 2'b00);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
